// File: rtl/regfile_sb.sv
// Multi-port register file: two write ports, two combinational read ports,
// same-cycle bypass, optional zero register and a per-register pending scoreboard.
module regfile_sb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int R0_ZERO = 0,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd0_pend,
    output logic              rd1_pend,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic              claim_ok,
    output logic [ADDR_W:0]   pend_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [DEPTH-1:0]  w_pend_nxt;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic              w_claim_zero;
    logic              w_claim_set;
    logic              w_wr0_ok;
    logic              w_wr1_ok;
    logic              w_dec0;
    logic              w_dec1;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (R0_ZERO != 0) && (a == '0);
    endfunction

    function automatic logic wr_hit(input logic [ADDR_W-1:0] a);
        return (wr0_en && (wr0_addr == a)) || (wr1_en && (wr1_addr == a));
    endfunction

    // wr1 is checked last so it takes priority over wr0; zero reg overrides both
    function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = r_mem[a];
        if ((BYPASS != 0) && wr0_en && (wr0_addr == a)) v = wr0_data;
        if ((BYPASS != 0) && wr1_en && (wr1_addr == a)) v = wr1_data;
        if (is_zero(a)) v = '0;
        return v;
    endfunction

    function automatic logic rd_pnd(input logic [ADDR_W-1:0] a);
        return r_pend[a] && !((BYPASS != 0) && wr_hit(a)) && !is_zero(a);
    endfunction

    assign rd0_data = rd_val(rd0_addr);
    assign rd1_data = rd_val(rd1_addr);
    assign rd0_pend = rd_pnd(rd0_addr);
    assign rd1_pend = rd_pnd(rd1_addr);

    assign w_claim_zero = is_zero(claim_addr);
    assign claim_ok     = claim_en && (w_claim_zero || !r_pend[claim_addr]);
    assign w_claim_set  = claim_ok && !w_claim_zero;
    assign w_wr0_ok     = wr0_en && !is_zero(wr0_addr);
    assign w_wr1_ok     = wr1_en && !is_zero(wr1_addr);
    assign pend_cnt     = r_cnt;

    // Same-address double write clears one bit, so only wr1 counts it
    assign w_dec0 = wr0_en && r_pend[wr0_addr]
                  && !(wr1_en && (wr1_addr == wr0_addr))
                  && !(w_claim_set && (claim_addr == wr0_addr));
    assign w_dec1 = wr1_en && r_pend[wr1_addr]
                  && !(w_claim_set && (claim_addr == wr1_addr));

    always_comb begin
        w_pend_nxt = r_pend;
        if (wr0_en) w_pend_nxt[wr0_addr] = 1'b0;
        if (wr1_en) w_pend_nxt[wr1_addr] = 1'b0;
        if (w_claim_set) w_pend_nxt[claim_addr] = 1'b1;
        w_cnt_nxt = r_cnt + (ADDR_W+1)'(w_claim_set)
                  - (ADDR_W+1)'(w_dec0) - (ADDR_W+1)'(w_dec1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr0_ok) r_mem[wr0_addr] <= wr0_data;
            if (w_wr1_ok) r_mem[wr1_addr] <= wr1_data;
            r_pend <= w_pend_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a default instance and an R0_ZERO=1
// instance share stimulus; expectations are queued and drained at sample points.
module tb_regfile_sb;
    localparam int DW = 16;
    localparam int AW = 4;

    localparam int RD0D = 0, RD1D = 1, RD0P = 2, RD1P = 3, COK = 4, CNT = 5;
    localparam int ZRD0D = 6, ZRD0P = 7, ZCOK = 8, ZCNT = 9;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr0_en, wr1_en, claim_en;
    logic [AW-1:0] wr0_addr, wr1_addr, rd0_addr, rd1_addr, claim_addr;
    logic [DW-1:0] wr0_data, wr1_data;
    logic [DW-1:0] rd0_data, rd1_data, z_rd0_data, z_rd1_data;
    logic          rd0_pend, rd1_pend, claim_ok;
    logic          z_rd0_pend, z_rd1_pend, z_claim_ok;
    logic [AW:0]   pend_cnt, z_pend_cnt;

    int   n_run = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .R0_ZERO(0), .BYPASS(1)) dut (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
        .rd0_data(rd0_data), .rd1_data(rd1_data),
        .rd0_pend(rd0_pend), .rd1_pend(rd1_pend),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .claim_ok(claim_ok), .pend_cnt(pend_cnt)
    );

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .R0_ZERO(1), .BYPASS(1)) dut_z (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
        .rd0_data(z_rd0_data), .rd1_data(z_rd1_data),
        .rd0_pend(z_rd0_pend), .rd1_pend(z_rd1_pend),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .claim_ok(z_claim_ok), .pend_cnt(z_pend_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            RD0D:    return 32'(rd0_data);
            RD1D:    return 32'(rd1_data);
            RD0P:    return 32'(rd0_pend);
            RD1P:    return 32'(rd1_pend);
            COK:     return 32'(claim_ok);
            CNT:     return 32'(pend_cnt);
            ZRD0D:   return 32'(z_rd0_data);
            ZRD0P:   return 32'(z_rd0_pend);
            ZCOK:    return 32'(z_claim_ok);
            ZCNT:    return 32'(z_pend_cnt);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic idle();
        wr0_en = 0; wr1_en = 0; claim_en = 0;
        wr0_addr = '0; wr1_addr = '0; claim_addr = '0;
        wr0_data = '0; wr1_data = '0;
    endtask

    task automatic edge_chk();
        @(posedge clk);
        #1 drain();
        @(negedge clk);
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        rd0_addr = '0;
        rd1_addr = '0;
        #2;
        for (int i = 0; i < 16; i++) begin
            rd0_addr = AW'(i);
            rd1_addr = AW'(15 - i);
            push("rst_rd0", RD0D, 0);
            push("rst_rd1", RD1D, 0);
            #1 drain();
        end
        push("rst_cnt", CNT, 0);
        #1 drain();
        @(negedge clk);
        reset = 0;

        @(negedge clk);
        wr0_en = 1; wr0_addr = 5; wr0_data = 16'h1234;
        wr1_en = 1; wr1_addr = 5; wr1_data = 16'hBEEF;
        rd0_addr = 5;
        push("byp_wr1_pri", RD0D, 16'hBEEF);
        #1 drain();
        edge_chk();
        wr0_en = 1; wr0_addr = 6; wr0_data = 16'h1111;
        wr1_en = 1; wr1_addr = 9; wr1_data = 16'h2222;
        rd0_addr = 5;
        push("arr_r5", RD0D, 16'hBEEF);
        #1 drain();
        edge_chk();
        rd0_addr = 6;
        rd1_addr = 9;
        push("arr_r6", RD0D, 16'h1111);
        push("arr_r9", RD1D, 16'h2222);
        #1 drain();

        claim_en = 1; claim_addr = 3;
        push("claim_r3", COK, 1);
        #1 drain();
        push("cnt_r3", CNT, 1);
        edge_chk();
        claim_en = 1; claim_addr = 3; rd1_addr = 3;
        push("reclaim_r3", COK, 0);
        push("pend_r3", RD1P, 1);
        #1 drain();
        push("cnt_reclaim", CNT, 1);
        edge_chk();
        wr1_en = 1; wr1_addr = 3; wr1_data = 16'h00AA; rd1_addr = 3;
        push("byp_pend_r3", RD1P, 0);
        push("byp_data_r3", RD1D, 16'h00AA);
        #1 drain();
        push("cnt_clr_r3", CNT, 0);
        edge_chk();

        claim_en = 1; claim_addr = 7;
        push("claim_r7", COK, 1);
        #1 drain();
        push("cnt_r7", CNT, 1);
        edge_chk();
        claim_en = 1; claim_addr = 7;
        wr0_en = 1; wr0_addr = 7; wr0_data = 16'h5555;
        push("cw_r7_set", COK, 0);
        #1 drain();
        push("cnt_cw_dec", CNT, 0);
        edge_chk();
        rd0_addr = 7;
        push("r7_cleared", RD0P, 0);
        #1 drain();
        claim_en = 1; claim_addr = 7;
        wr0_en = 1; wr0_addr = 7; wr0_data = 16'h5555;
        push("cw_r7_clr", COK, 1);
        #1 drain();
        push("cnt_cw_inc", CNT, 1);
        edge_chk();
        rd0_addr = 7;
        push("r7_still_pend", RD0P, 1);
        push("r7_data", RD0D, 16'h5555);
        #1 drain();
        wr0_en = 1; wr0_addr = 7; wr0_data = 16'h5555;
        push("cnt_r7_done", CNT, 0);
        edge_chk();

        wr0_en = 1; wr0_addr = 0; wr0_data = 16'hFFFF;
        claim_en = 1; claim_addr = 0; rd0_addr = 0;
        push("z_claim_r0", ZCOK, 1);
        push("z_rd_r0_byp", ZRD0D, 0);
        push("z_pend_r0", ZRD0P, 0);
        #1 drain();
        push("z_cnt_r0", ZCNT, 0);
        push("cnt_r0_plain", CNT, 1);
        edge_chk();
        rd0_addr = 0;
        push("z_rd_r0", ZRD0D, 0);
        push("rd_r0_plain", RD0D, 16'hFFFF);
        push("pend_r0_plain", RD0P, 1);
        #1 drain();

        wr0_en = 1; wr0_addr = 2; wr0_data = 16'hABCD;
        edge_chk();
        rd0_addr = 2;
        push("pre_rst_r2", RD0D, 16'hABCD);
        #1 drain();
        #1 reset = 1;
        push("mid_rst_rd", RD0D, 0);
        push("mid_rst_cnt", CNT, 0);
        #1 drain();
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            claim_en = 1; claim_addr = AW'(i);
            push($sformatf("claim_all_%0d", i), COK, 1);
            #1 drain();
        end
        @(negedge clk);
        idle();
        push("cnt_full", CNT, 16);
        push("z_cnt_full", ZCNT, 15);
        #1 drain();
        claim_en = 1; claim_addr = 0;
        push("claim_full", COK, 0);
        #1 drain();
        push("cnt_no_wrap", CNT, 16);
        edge_chk();
        wr0_en = 1; wr0_addr = 4; wr0_data = 16'h0404;
        wr1_en = 1; wr1_addr = 11; wr1_data = 16'h0B0B;
        push("cnt_dual_clr", CNT, 14);
        push("z_cnt_dual_clr", ZCNT, 13);
        edge_chk();
        wr0_en = 1; wr0_addr = 12; wr0_data = 16'h0C0C;
        wr1_en = 1; wr1_addr = 12; wr1_data = 16'h0CCC;
        push("cnt_same_clr", CNT, 13);
        edge_chk();
        rd1_addr = 12;
        push("r12_wr1_wins", RD1D, 16'h0CCC);
        #1 drain();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-port register file, the successor to the fixed 16x16 two-read/one-write file in the ORCS datapath. It adds:
- a second write port, for load/multicycle returns;
- same-cycle write-to-read bypass;
- an optional hard-wired zero register;
- a per-register pending scoreboard so the issue stage can detect RAW hazards and stall.

It sits between decode/issue (claims, reads) and the ALU/memory writeback paths.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, address width; depth = 2**ADDR_W
R0_ZERO, 0, 1 = register 0 reads as zero, ignores writes and claims
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
wr0_en  in  1  ALU writeback enable
wr0_addr  in  ADDR_W  ALU writeback address
wr0_data  in  DATA_W  ALU writeback data
wr1_en  in  1  load/multicycle writeback enable
wr1_addr  in  ADDR_W  load writeback address
wr1_data  in  DATA_W  load writeback data
rd0_addr  in  ADDR_W  read port 0 address
rd1_addr  in  ADDR_W  read port 1 address
rd0_data  out  DATA_W  read port 0 data (combinational)
rd1_data  out  DATA_W  read port 1 data (combinational)
rd0_pend  out  1  read port 0 source is pending
rd1_pend  out  1  read port 1 source is pending
claim_en  in  1  issue stage marks a destination register pending
claim_addr  in  ADDR_W  destination to claim
claim_ok  out  1  claim accepted (combinational)
pend_cnt  out  ADDR_W+1  registered count of pending registers

Behaviour:
Interface:
- One clock, clk. Reset is asynchronous and active-high, named reset.
- While reset is high: all registers = 0, all pending bits = 0, pend_cnt = 0.
- Reset asserted mid-operation discards in-flight claims and writes immediately; it does not wait for a clock edge.

Writes:
- Written on the clk rising edge.
- wr0 and wr1 to the same address in the same cycle: wr1 wins, and the wr0 data is dropped.
- With R0_ZERO=1, writes to address 0 are dropped.

Reads:
- rd_data = array[rd_addr], combinational.
- With BYPASS=1: if a write to rd_addr is active this cycle, rd_data returns that write's data. wr1 data has priority over wr0 data.
- With R0_ZERO=1, address 0 always reads 0, which overrides bypass.

Scoreboard (one pending bit per register):
- claim_ok = claim_en & !pend[claim_addr]. Exception: when R0_ZERO=1 and claim_addr=0, claim_ok = claim_en and no bit is set.
- An accepted claim sets pend[claim_addr] on the next edge.
- A rejected claim (already pending) changes nothing; the issue stage must retry.
- Any write (wr0 or wr1) clears pend[wr_addr] on the edge, whether or not the bit was set.
- Claim and write to the same address in the same cycle: the claim wins, so the bit is set after the edge. The write data still commits, and claim_ok is evaluated on the pre-edge bit.
- rd_pend = pend[rd_addr] & !(BYPASS & write active to rd_addr this cycle). When R0_ZERO=1, address 0 is never pending.

pend_cnt:
- Registered: pend_cnt = popcount of the pending bits after the edge.
- Updated incrementally: +1 per accepted claim that sets a clear bit; -1 per distinct address whose set bit is cleared by a write and not re-set by a same-cycle claim.
- The 2 writes plus 1 claim can give a net change of -2..+1 per cycle.
- Never wraps. Maximum is 2**ADDR_W, or 2**ADDR_W-1 when R0_ZERO=1.

Test Plan:
- Reset, then read all 16 addresses -> rd0_data = rd1_data = 0x0000, pend_cnt = 0; assert reset mid-stream after writes -> outputs return to 0 with no clock edge.
- Write 0x1234 to r5 via wr0 and 0xBEEF to r5 via wr1 in the same cycle, rd0_addr=5 that cycle -> rd0_data = 0xBEEF (bypass); next cycle array r5 reads 0xBEEF.
- claim r3 -> claim_ok=1, next cycle rd1_addr=3 gives rd1_pend=1 and pend_cnt=1; re-claim r3 -> claim_ok=0 and pend_cnt stays 1; wr1 to r3 with 0x00AA -> that cycle rd1_pend=0, rd1_data=0x00AA; after the edge pend_cnt=0.
- Same-cycle claim r7 and wr0 to r7 with 0x5555 (r7 pending beforehand) -> claim_ok=0 (bit was set), bit cleared, pend_cnt decrements by 1; repeat with r7 not pending -> claim_ok=1, bit stays set, pend_cnt increments by 1, r7 = 0x5555.
- R0_ZERO=1: write 0xFFFF to r0, claim r0 -> claim_ok=1, rd0_data=0, rd0_pend=0, pend_cnt unchanged.
- Claim all 16 registers on successive cycles -> pend_cnt = 16 (ADDR_W=4, R0_ZERO=0), no wrap; then wr0 and wr1 clear two distinct registers in the same cycle -> pend_cnt = 14.
